// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
//   HexSeg          : active-low {g..a} patterns for hex digits 0..F
//   MaxDigits       : upper bound on NUM_DIGITS (also the anode helper width)
//   MinDivBits      : lower bound on DIV_BITS (PWM compares the top 4 bits)
//   digits_in_range : elaboration-time range check for NUM_DIGITS
//   seg_to_pins     : active-low segment byte -> pin polarity
//   anode_to_pins   : active-high anode vector -> pin polarity
package seg7_pkg;

  localparam int unsigned MaxDigits  = 16;
  localparam int unsigned MinDivBits = 4;

  localparam logic [6:0] HexSeg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic bit digits_in_range(int unsigned n);
    return (n >= 1) && (n <= MaxDigits);
  endfunction

  function automatic logic [7:0] seg_to_pins(logic [7:0] seg_al, bit active_low);
    return active_low ? seg_al : ~seg_al;
  endfunction

  function automatic logic [MaxDigits-1:0] anode_to_pins(logic [MaxDigits-1:0] lit,
                                                         bit active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bus bundle between the status-register side and the display driver.
//   master : drives disp_num/dp/blank/update/lz_suppress/brightness,
//            observes digit_anode/segment/frame_done
//   slave  : the display driver itself
interface seg7_scan_display_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] disp_num;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    update;
  logic                    lz_suppress;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   digit_anode;
  logic [7:0]              segment;
  logic                    frame_done;

  modport master (
    output disp_num, dp, blank, update, lz_suppress, brightness,
    input  digit_anode, segment, frame_done
  );

  modport slave (
    input  disp_num, dp, blank, update, lz_suppress, brightness,
    output digit_anode, segment, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Hex nibble + decimal point to active-low segment byte {dp, g, f, e, d, c, b, a}.
//   nibble_i : hex digit 0..F
//   dp_i     : 1 = decimal point lit
//   seg_o    : active-low segments (0 = lit)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = {~dp_i, HexSeg[nibble_i]};
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver with per-digit dp/blanking, leading-zero
// suppression, 16-level PWM brightness and frame-synchronous value update.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seg7_scan_display_if (value inputs, live controls,
//           registered digit_anode/segment pins and frame_done pulse)
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 8,
  parameter int unsigned DIV_BITS         = 10,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_display_if.slave bus
);

  if (!digits_in_range(NUM_DIGITS) || (DIV_BITS < MinDivBits)) begin : g_param_check
    $error("seg7_scan_display: NUM_DIGITS or DIV_BITS out of range");
  end

  localparam int unsigned           IdxW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0]       IdxLast     = IdxW'(NUM_DIGITS - 1);
  localparam logic [MaxDigits-1:0]  AnodeOffAll = anode_to_pins('0, ANODE_ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] AnodeOff    = AnodeOffAll[NUM_DIGITS-1:0];
  localparam logic [7:0]            SegOff      = seg_to_pins(8'hFF, SEG_ACTIVE_LOW);

  logic [DIV_BITS-1:0]     div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_num_q, pend_num_d, shad_num_q, shad_num_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, shad_blank_q, shad_blank_d;
  logic                    pend_v_q, pend_v_d;
  logic [NUM_DIGITS-1:0]   lz_mask_q, lz_mask_d;
  logic [NUM_DIGITS-1:0]   digit_anode_q, digit_anode_d;
  logic [7:0]              segment_q, segment_d;
  logic                    frame_done_q, frame_done_d;

  logic                    div_wrap, frame_bnd;
  logic                    upper_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp, pwm_off, dark;
  logic [7:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   anode_lit;
  logic [MaxDigits-1:0]    anode_pins;

  // Scan counters; frame boundary is the last clock of the last digit.
  always_comb begin
    div_wrap  = &div_cnt_q;
    frame_bnd = div_wrap && (idx_q == IdxLast);
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Pending/shadow double buffer. The transfer at the boundary uses the old
  // pending contents; an update on that same cycle re-arms pending.
  always_comb begin
    pend_num_d   = pend_num_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_v_d     = pend_v_q;
    shad_num_d   = shad_num_q;
    shad_dp_d    = shad_dp_q;
    shad_blank_d = shad_blank_q;
    if (frame_bnd && pend_v_q) begin
      shad_num_d   = pend_num_q;
      shad_dp_d    = pend_dp_q;
      shad_blank_d = pend_blank_q;
      pend_v_d     = 1'b0;
    end
    if (bus.update) begin
      pend_num_d   = bus.disp_num;
      pend_dp_d    = bus.dp;
      pend_blank_d = bus.blank;
      pend_v_d     = 1'b1;
    end
  end

  // Bit i set when nibbles i..top are all zero; built from the next shadow value
  // so the registered mask always matches the shadow it is used with.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask_d  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (shad_num_d[4*i +: 4] == 4'h0);
      if (i > 0) begin
        lz_mask_d[i] = upper_zero;
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .seg_o    (dec_seg)
  );

  // Anode and segments are both computed from the same counter state and
  // registered together, so they never skew.
  always_comb begin
    cur_nib       = shad_num_q[{idx_q, 2'b00} +: 4];
    cur_dp        = shad_dp_q[idx_q];
    pwm_off       = div_cnt_q[DIV_BITS-1 -: 4] > bus.brightness;
    dark          = shad_blank_q[idx_q] | (bus.lz_suppress & lz_mask_q[idx_q]) | pwm_off;
    anode_lit     = dark ? '0 : (NUM_DIGITS'(1) << idx_q);
    anode_pins    = anode_to_pins(MaxDigits'(anode_lit), ANODE_ACTIVE_LOW);
    digit_anode_d = anode_pins[NUM_DIGITS-1:0];
    segment_d     = seg_to_pins(dark ? 8'hFF : dec_seg, SEG_ACTIVE_LOW);
    frame_done_d  = frame_bnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      pend_num_q    <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_v_q      <= 1'b0;
      shad_num_q    <= '0;
      shad_dp_q     <= '0;
      shad_blank_q  <= '0;
      lz_mask_q     <= '0;
      digit_anode_q <= AnodeOff;
      segment_q     <= SegOff;
      frame_done_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      pend_num_q    <= pend_num_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_v_q      <= pend_v_d;
      shad_num_q    <= shad_num_d;
      shad_dp_q     <= shad_dp_d;
      shad_blank_q  <= shad_blank_d;
      lz_mask_q     <= lz_mask_d;
      digit_anode_q <= digit_anode_d;
      segment_q     <= segment_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.digit_anode = digit_anode_q;
  assign bus.segment     = segment_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: an 8-digit active-low instance exercising
// scan order, decode, frame-synchronous update, leading-zero suppression, dp,
// blanking and PWM, plus a 6-digit active-high instance for wrap and reset.
module tb_seg7_scan_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na;
  logic rst_nb;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  seg7_scan_display_if #(.NUM_DIGITS(8)) bus_a ();
  seg7_scan_display_if #(.NUM_DIGITS(6)) bus_b ();

  seg7_scan_display #(
    .NUM_DIGITS       (8),
    .DIV_BITS         (4),
    .SEG_ACTIVE_LOW   (1'b1),
    .ANODE_ACTIVE_LOW (1'b1)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_na),
    .bus   (bus_a)
  );

  seg7_scan_display #(
    .NUM_DIGITS       (6),
    .DIV_BITS         (4),
    .SEG_ACTIVE_LOW   (1'b0),
    .ANODE_ACTIVE_LOW (1'b0)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_nb),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame_a(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus_a.frame_done) seen = 1'b1;
    end
    check("frame_done_a seen", 64'(seen), 64'd1);
  endtask

  // One full frame of instance A, starting just after a frame_done sample.
  // seg_exp holds the active-low byte per digit {d7..d0}; dark_mask marks
  // digits expected dark; an optional update is driven at sample upd_at.
  task automatic scan_a(input string tag, input logic [63:0] seg_exp,
                        input logic [7:0] dark_mask, input int bright, input int upd_at,
                        input logic [31:0] upd_num, input logic [7:0] upd_dp,
                        input logic [7:0] upd_blk);
    logic [7:0] one_hot;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    bit         lit;
    int         d;
    int         dv;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      d       = j / 16;
      dv      = j % 16;
      lit     = !dark_mask[d] && (dv <= bright);
      one_hot = 8'h01 << d;
      exp_an  = lit ? ~one_hot : 8'hFF;
      exp_seg = lit ? seg_exp[8*d +: 8] : 8'hFF;
      check($sformatf("%s anode j=%0d", tag, j), 64'(bus_a.digit_anode), 64'(exp_an));
      check($sformatf("%s seg j=%0d", tag, j), 64'(bus_a.segment), 64'(exp_seg));
      check($sformatf("%s fdone j=%0d", tag, j), 64'(bus_a.frame_done), 64'(j == 127));
      bus_a.update = 1'b0;
      if (j == upd_at) begin
        bus_a.disp_num = upd_num;
        bus_a.dp       = upd_dp;
        bus_a.blank    = upd_blk;
        bus_a.update   = 1'b1;
      end
    end
  endtask

  // Instance B with an all-zero shadow: every digit shows "0" (3F active-high).
  task automatic scan_b(input string tag, input int cycles, input int upd_at);
    logic [5:0] one_hot;
    int         idx;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      idx     = ((k - 1) / 16) % 6;
      one_hot = 6'h01 << idx;
      check($sformatf("%s anode k=%0d", tag, k), 64'(bus_b.digit_anode), 64'(one_hot));
      check($sformatf("%s seg k=%0d", tag, k), 64'(bus_b.segment), 64'h3F);
      check($sformatf("%s fdone k=%0d", tag, k), 64'(bus_b.frame_done), 64'(k % 96 == 0));
      bus_b.update = 1'b0;
      if (k == upd_at) begin
        bus_b.disp_num = 24'h11_1111;
        bus_b.update   = 1'b1;
      end
    end
  endtask

  localparam logic [63:0] SegHexF = 64'h80_90_88_83_C6_A1_86_8E;
  localparam logic [63:0] SegOne  = 64'hC0_C0_C0_C0_C0_C0_C0_F9;
  localparam logic [63:0] SegTwo  = 64'hA4_A4_A4_A4_A4_A4_A4_A4;
  localparam logic [63:0] SegThr  = 64'hB0_B0_B0_B0_B0_B0_B0_B0;
  localparam logic [63:0] SegLz   = 64'hFF_FF_FF_FF_FF_99_A4_C0;
  localparam logic [63:0] SegZero = 64'hFF_FF_FF_FF_FF_FF_FF_C0;
  localparam logic [63:0] SegDp   = 64'hFF_90_88_83_C6_21_86_8E;

  initial begin
    rst_na = 1'b1;
    rst_nb = 1'b1;
    bus_a.disp_num = '0;  bus_a.dp = '0;  bus_a.blank = '0;
    bus_a.update = 1'b0;  bus_a.lz_suppress = 1'b0;  bus_a.brightness = 4'd15;
    bus_b.disp_num = '0;  bus_b.dp = '0;  bus_b.blank = '0;
    bus_b.update = 1'b0;  bus_b.lz_suppress = 1'b0;  bus_b.brightness = 4'd15;
    #2;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    @(negedge clk);
    check("rst_a anode", 64'(bus_a.digit_anode), 64'hFF);
    check("rst_a seg", 64'(bus_a.segment), 64'hFF);
    check("rst_a fdone", 64'(bus_a.frame_done), 64'h0);
    check("rst_b anode", 64'(bus_b.digit_anode), 64'h0);
    check("rst_b seg", 64'(bus_b.segment), 64'h0);
    check("rst_b fdone", 64'(bus_b.frame_done), 64'h0);

    @(negedge clk);
    rst_na         = 1'b1;
    bus_a.disp_num = 32'h89AB_CDEF;
    bus_a.update   = 1'b1;
    @(negedge clk);
    bus_a.update   = 1'b0;
    wait_frame_a(400);

    scan_a("f1", SegHexF, 8'h00, 15, -1, 32'h0, 8'h00, 8'h00);
    scan_a("f2", SegHexF, 8'h00, 15, 40, 32'h0000_0001, 8'h00, 8'h00);
    scan_a("f3", SegOne, 8'h00, 15, 10, 32'h2222_2222, 8'h00, 8'h00);
    // Update landing on the boundary cycle shows only from the frame after next.
    scan_a("f4", SegTwo, 8'h00, 15, 126, 32'h3333_3333, 8'h00, 8'h00);
    scan_a("f5", SegTwo, 8'h00, 15, -1, 32'h0, 8'h00, 8'h00);
    bus_a.lz_suppress = 1'b1;
    scan_a("f6", SegThr, 8'h00, 15, 50, 32'h0000_0420, 8'h00, 8'h00);
    scan_a("f7", SegLz, 8'hF8, 15, 30, 32'h0000_0000, 8'h00, 8'h00);
    scan_a("f8", SegZero, 8'hFE, 15, 30, 32'h89AB_CDEF, 8'h04, 8'h80);
    scan_a("f9", SegDp, 8'h80, 15, -1, 32'h0, 8'h00, 8'h00);
    bus_a.brightness = 4'd3;
    scan_a("f10", SegDp, 8'h80, 3, -1, 32'h0, 8'h00, 8'h00);

    // Instance B: wrap 5 -> 0, then a mid-scan reset that must drop pending.
    rst_nb = 1'b1;
    scan_b("b1", 150, 100);
    rst_nb = 1'b0;
    #1;
    check("b rst anode", 64'(bus_b.digit_anode), 64'h0);
    check("b rst seg", 64'(bus_b.segment), 64'h0);
    check("b rst fdone", 64'(bus_b.frame_done), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_nb = 1'b1;
    scan_b("b2", 120, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
